// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the push-button conditioning logic.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        PRESSED      = 3'd2,
        LONG_HELD    = 3'd3,
        RELEASE_WAIT = 3'd4
    } key_state_e;

    // Cycles in ms milliseconds at clk_hz, never less than one cycle.
    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz,
                                              input int unsigned ms);
        int unsigned c;
        c = (clk_hz / 1000) * ms;
        return (c == 0) ? 1 : c;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Raw key pin plus the conditioned level and event pulses.
interface key_debounce_if;
    logic key_in;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic long_pulse;

    modport master (
        output key_in,
        input  key_level, press_pulse, release_pulse, short_pulse, long_pulse
    );

    modport slave (
        input  key_in,
        output key_level, press_pulse, release_pulse, short_pulse, long_pulse
    );
endinterface

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchronizer with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Both stages reset to RST_VAL so no false edge appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounces one push-button and classifies presses as short or long.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 27000000,
    parameter int unsigned DEBOUNCE_MS    = 20,
    parameter int unsigned LONG_MS        = 1000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    key_debounce_if.slave  kif
);

    localparam int unsigned DEBOUNCE_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC     = ms_to_cyc(CLK_HZ, LONG_MS);
    localparam int unsigned CW           = $clog2(LONG_CYC + 1);

    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYC);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic          REL_LVL  = KEY_ACTIVE_LOW;

    key_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] hold_q;
    logic          long_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          short_q;
    logic          long_pulse_q;

    logic          key_sync;
    logic          s_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + ONE;
    endfunction

    // The pin is only ever seen through the synchronizer.
    sync_2ff #(
        .RST_VAL (REL_LVL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kif.key_in),
        .q     (key_sync)
    );

    // Normalise polarity so s_c = 1 means pressed.
    assign s_c = key_sync ^ REL_LVL;

    // Debounce / hold-classification FSM with registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            long_q       <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            short_q      <= 1'b0;
            long_pulse_q <= 1'b0;
        end else begin
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            short_q      <= 1'b0;
            long_pulse_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (s_c) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= ONE;
                    end
                end

                PRESS_WAIT: begin
                    if (!s_c) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_MAX) begin
                        state_q <= PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        hold_q  <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end

                // Hold counter freezes while a possible release is debounced.
                PRESSED: begin
                    if (!s_c) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= ONE;
                        long_q  <= 1'b0;
                    end else begin
                        hold_q <= sat_inc(hold_q);
                        if (hold_q == LONG_MAX - ONE) begin
                            long_pulse_q <= 1'b1;
                            state_q      <= LONG_HELD;
                        end
                    end
                end

                LONG_HELD: begin
                    if (!s_c) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= ONE;
                        long_q  <= 1'b1;
                    end
                end

                // Bounce goes back to the held state without re-firing press.
                RELEASE_WAIT: begin
                    if (s_c) begin
                        state_q <= long_q ? LONG_HELD : PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_MAX) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        short_q   <= ~long_q;
                        long_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign kif.key_level     = level_q;
    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = release_q;
    assign kif.short_pulse   = short_q;
    assign kif.long_pulse    = long_pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: DEBOUNCE_CYC = 4, LONG_CYC = 20, active-low key.
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    key_debounce_if kif ();

    key_debounce #(
        .CLK_HZ         (1000),
        .DEBOUNCE_MS    (4),
        .LONG_MS        (20),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    // One segment: hold key for n edges; edge 0 is the first edge that samples it.
    // Expected pulse entries give the edge index of the single pulse, or -1 for none.
    typedef struct {
        logic key;
        int   n;
        int   exp_p;
        int   exp_r;
        int   exp_s;
        int   exp_l;
        logic exp_lvl;
    } seg_t;

    localparam int NSEG = 21;
    seg_t tbl [NSEG];

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs_zero(input string name);
        check_int({name, " key_level"},     int'(kif.key_level),     0);
        check_int({name, " press_pulse"},   int'(kif.press_pulse),   0);
        check_int({name, " release_pulse"}, int'(kif.release_pulse), 0);
        check_int({name, " short_pulse"},   int'(kif.short_pulse),   0);
        check_int({name, " long_pulse"},    int'(kif.long_pulse),    0);
    endtask

    // Advance one edge, sample 1 time unit later and check pulse exclusivity.
    task automatic step();
        int hi;
        @(posedge clk);
        #1;
        hi = int'(kif.press_pulse) + int'(kif.release_pulse) + int'(kif.long_pulse);
        check_int("pulse_exclusive", (hi > 1) ? 1 : 0, 0);
        check_int("short_with_release",
                  (kif.short_pulse && !kif.release_pulse) ? 1 : 0, 0);
    endtask

    function automatic int pulse_at(input int cnt, input int first);
        return (cnt == 0) ? -1 : ((cnt == 1) ? first : -2);
    endfunction

    task automatic run_seg(input string name, input seg_t sg);
        int cp, cr, cs, cl;
        int fp, fr, fs, fl;
        cp = 0; cr = 0; cs = 0; cl = 0;
        fp = 0; fr = 0; fs = 0; fl = 0;
        kif.key_in = sg.key;
        for (int i = 0; i < sg.n; i++) begin
            step();
            if (kif.press_pulse)   begin if (cp == 0) fp = i; cp++; end
            if (kif.release_pulse) begin if (cr == 0) fr = i; cr++; end
            if (kif.short_pulse)   begin if (cs == 0) fs = i; cs++; end
            if (kif.long_pulse)    begin if (cl == 0) fl = i; cl++; end
        end
        check_int({name, " press_edge"},   pulse_at(cp, fp), sg.exp_p);
        check_int({name, " release_edge"}, pulse_at(cr, fr), sg.exp_r);
        check_int({name, " short_edge"},   pulse_at(cs, fs), sg.exp_s);
        check_int({name, " long_edge"},    pulse_at(cl, fl), sg.exp_l);
        check_int({name, " level_end"},    int'(kif.key_level), int'(sg.exp_lvl));
    endtask

    initial begin
        seg_t sg;

        // Clean short press.
        tbl[0]  = '{1'b0, 10,  6, -1, -1, -1, 1'b1};
        tbl[1]  = '{1'b1, 10, -1,  6,  6, -1, 1'b0};
        // Bounce: alternate single-cycle low/high for 12 cycles, then settle high.
        for (int i = 0; i < 12; i++)
            tbl[2 + i] = '{((i % 2) == 0) ? 1'b0 : 1'b1, 1, -1, -1, -1, -1, 1'b0};
        tbl[14] = '{1'b1, 10, -1, -1, -1, -1, 1'b0};
        // Long press: long_pulse 20 edges after press_pulse.
        tbl[15] = '{1'b0, 40,  6, -1, -1, 26, 1'b1};
        tbl[16] = '{1'b1, 10, -1,  6, -1, -1, 1'b0};
        // Release bounce: 2-cycle high glitch at edges 12-13; three frozen
        // hold cycles (edges 14-16) push long_pulse from edge 26 to edge 29.
        tbl[17] = '{1'b0, 12,  6, -1, -1, -1, 1'b1};
        tbl[18] = '{1'b1,  2, -1, -1, -1, -1, 1'b1};
        tbl[19] = '{1'b0, 20, -1, -1, -1, 15, 1'b1};
        tbl[20] = '{1'b1, 10, -1,  6, -1, -1, 1'b0};

        // Reset held with the key pressed: nothing may come out.
        kif.key_in = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_outs_zero("in_reset");
        end
        rst_n = 1'b1;
        sg = '{1'b0, 10, 6, -1, -1, -1, 1'b1};
        run_seg("post_reset_press", sg);
        sg = '{1'b1, 10, -1, 6, 6, -1, 1'b0};
        run_seg("post_reset_release", sg);

        for (int k = 0; k < NSEG; k++)
            run_seg($sformatf("seg%0d", k), tbl[k]);

        // Reset mid-press at hold = 10 (edge 16), key kept pressed.
        sg = '{1'b0, 17, 6, -1, -1, -1, 1'b1};
        run_seg("mid_press_hold", sg);
        rst_n = 1'b0;
        #1;
        check_outs_zero("mid_reset_now");
        for (int i = 0; i < 2; i++) begin
            step();
            check_outs_zero("mid_reset_held");
        end
        rst_n = 1'b1;
        sg = '{1'b0, 10, 6, -1, -1, -1, 1'b1};
        run_seg("re_accept_press", sg);
        sg = '{1'b1, 10, -1, 6, 6, -1, 1'b0};
        run_seg("re_accept_release", sg);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one raw push-button pin on the Tang Nano 20K (27 MHz board clock) into clean single-cycle events.
- Sits directly upstream of the LED blink logic. Its press, short-press and long-press pulses drive blink enable, rate select and phase toggling.
- Covers metastability, contact bounce and press-duration classification.

Parameters:
- CLK_HZ, 27000000, input clock frequency in Hz.
- DEBOUNCE_MS, 20, time the pin must be stable before a level change is accepted.
- LONG_MS, 1000, hold time after the accepted press that classifies a press as long.
- KEY_ACTIVE_LOW, 1, 1 = pressed reads 0 on key_in; 0 = pressed reads 1.

Derived constants:
- DEBOUNCE_CYC = CLK_HZ/1000*DEBOUNCE_MS, minimum 1.
- LONG_CYC = CLK_HZ/1000*LONG_MS, must be greater than DEBOUNCE_CYC.
- Counter width = $clog2(LONG_CYC+1).

Ports:
- clk  input  1  board clock.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  1  raw asynchronous button pin.
- key_level  output  1  debounced level, 1 = pressed.
- press_pulse  output  1  one-cycle pulse on accepted press.
- release_pulse  output  1  one-cycle pulse on accepted release.
- short_pulse  output  1  one-cycle pulse on release of a press that never reached LONG_CYC.
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_CYC; at most once per press.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - While rst_n = 0, all outputs are 0, the FSM is in IDLE and counters are 0.
  - Both synchronizer flops reset to the released level: 1 if KEY_ACTIVE_LOW, else 0.
  - Reset mid-press drops to IDLE with no pulses. A button still held after reset must be re-accepted through the full debounce before press_pulse.
- Input path:
  - Two-flop synchronizer, then polarity normalisation. The result is s, with 1 = pressed.
  - key_in goes through the synchronizer only; no other logic samples it.
- FSM states and transitions:
  - IDLE: waits for a press. If s = 1, go to PRESS_WAIT with cnt = 1.
  - PRESS_WAIT: if s = 0, return to IDLE with cnt = 0. If s = 1 and cnt = DEBOUNCE_CYC, go to PRESSED; key_level = 1 and press_pulse = 1 for that cycle; load hold = 0. Otherwise cnt increments.
  - PRESSED:
    - hold increments every cycle.
    - When hold reaches LONG_CYC, long_pulse = 1 for one cycle and the FSM goes to LONG_HELD.
    - If s = 0, go to RELEASE_WAIT with cnt = 1 and remember long = 0. The hold counter freezes.
  - LONG_HELD: if s = 0, go to RELEASE_WAIT with cnt = 1 and remember long = 1.
  - RELEASE_WAIT:
    - If s = 1 (bounce), return to the state it came from. The hold counter resumes from its frozen value, so bounce never re-fires press_pulse.
    - If s = 0 and cnt = DEBOUNCE_CYC, go to IDLE with key_level = 0 and release_pulse = 1.
    - In that same cycle, short_pulse = 1 only if long = 0.
    - Otherwise cnt increments.
- Timing (latency):
  - With clean input, press_pulse asserts exactly 2 + DEBOUNCE_CYC rising edges after the first edge that sees key_in pressed.
  - Release behaves the same way for release_pulse.
  - long_pulse asserts exactly LONG_CYC cycles after press_pulse, excluding frozen bounce cycles.
- Exclusivity:
  - press_pulse, release_pulse and long_pulse are never high in the same cycle.
  - short_pulse only coincides with release_pulse.
- Counter width: counters saturate and never wrap. LONG_HELD performs no counting.
- All outputs are registered; no combinational path runs from key_in.

Decomposition:
- Package key_pkg holds:
  - the FSM state enum (IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT);
  - a function computing cycle counts from CLK_HZ and ms, with the minimum-1 clamp.
- One sub-module, sync_2ff: a parameterised-reset-value two-flop synchronizer, reusable for the board's other keys.

Test Plan:
Bench parameters: CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20, so DEBOUNCE_CYC = 4 and LONG_CYC = 20. KEY_ACTIVE_LOW = 1.
- Reset: hold rst_n = 0 with key_in = 0. All outputs must stay 0, and no press_pulse may appear until 6 cycles after release of reset.
- Clean short press: drive key_in low for 10 cycles, then high. Required response:
  - press_pulse at edge 6;
  - key_level = 1 from edge 6;
  - release_pulse and short_pulse together 6 edges after the rising edge of key_in;
  - long_pulse never.
- Bounce rejection: toggle key_in with a 2-cycle period for 12 cycles, then hold high. All pulses must stay 0 and key_level must stay 0.
- Long press: hold key_in low for 40 cycles. Required response:
  - press_pulse at edge 6;
  - long_pulse at edge 26, exactly once;
  - on release, release_pulse with short_pulse = 0.
- Release bounce: during a held press, pulse key_in high for 2 cycles, then low again. There must be no release_pulse, no second press_pulse, and long_pulse timing shifts by the 2 frozen cycles plus synchronizer slack.
- Reset mid-press: assert rst_n low at hold = 10, then deassert with the key still held. All outputs must go 0 immediately. press_pulse must re-fire 6 edges after deassertion.
